// File: rtl/seg7_text_scroller.sv
// seg7_text_scroller
//   Multi-digit ASCII text driver for active-low 7-segment displays. A host
//   appends characters through a valid/ready port. The buffered text is shown
//   either statically (left-aligned) or scrolling right-to-left. In scroll mode
//   the text is followed by N_DIGITS blanks before it repeats.
//
// Parameters
//   N_DIGITS   number of digits driven
//   BUF_DEPTH  maximum characters held (>= 1)
//   TICK_DIV   clk cycles per scroll step (>= 1)
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   wr_valid   host presents a character on wr_data
//   wr_data    7-bit ASCII code
//   wr_ready   buffer can accept (write on wr_valid & wr_ready)
//   clear      synchronous buffer flush, wins over a same-cycle write
//   scroll_en  0 = static, 1 = scrolling
//   len        number of characters currently held
//   seg_out    registered active-low segments {dp,g,f,e,d,c,b,a} per digit,
//              digit 0 (leftmost) in the top byte
module seg7_text_scroller #(
  parameter int N_DIGITS  = 6,
  parameter int BUF_DEPTH = 32,
  parameter int TICK_DIV  = 25_000_000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_valid,
  input  logic [6:0]                     wr_data,
  output logic                           wr_ready,
  input  logic                           clear,
  input  logic                           scroll_en,
  output logic [$clog2(BUF_DEPTH+1)-1:0] len,
  output logic [8*N_DIGITS-1:0]          seg_out
);

  localparam int LW = $clog2(BUF_DEPTH + 1);
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  // Wide enough for pos+k, which can reach len + 2*N_DIGITS - 2 before wrapping.
  localparam int PW = $clog2(BUF_DEPTH + 2*N_DIGITS + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  // Active-high glyphs for codes 0x20..0x7E, bit order {dp,g,f,e,d,c,b,a}.
  localparam logic [7:0] GLYPH [0:94] = '{
    8'h00, 8'h86, 8'h22, 8'h7E, 8'h6D, 8'hD2, 8'h46, 8'h20,
    8'h29, 8'h0B, 8'h21, 8'h70, 8'h10, 8'h40, 8'h80, 8'h52,
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h09, 8'h0D, 8'h61, 8'h48, 8'h43, 8'hD3,
    8'h5F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D,
    8'h76, 8'h30, 8'h1E, 8'h75, 8'h38, 8'h15, 8'h37, 8'h3F,
    8'h73, 8'h6B, 8'h33, 8'h6D, 8'h78, 8'h3E, 8'h3E, 8'h2A,
    8'h76, 8'h6E, 8'h5B, 8'h39, 8'h64, 8'h0F, 8'h23, 8'h08,
    8'h02, 8'h5F, 8'h7C, 8'h58, 8'h5E, 8'h7B, 8'h71, 8'h6F,
    8'h74, 8'h10, 8'h0C, 8'h75, 8'h30, 8'h14, 8'h54, 8'h5C,
    8'h73, 8'h67, 8'h50, 8'h6D, 8'h78, 8'h1C, 8'h1C, 8'h14,
    8'h76, 8'h6E, 8'h5B, 8'h46, 8'h30, 8'h70, 8'h01
  };

  // Control codes and DEL are blank rather than wrapping into the table.
  function automatic logic [7:0] glyph_of(input logic [6:0] c);
    logic [7:0] res;
    if (c < 7'h20 || c == 7'h7F) res = 8'hFF;
    else                         res = ~GLYPH[c - 7'h20];
    return res;
  endfunction

  logic [6:0]           buf_q [BUF_DEPTH];
  logic [LW-1:0]        len_q, len_d;
  logic [PW-1:0]        pos_q, pos_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic                 scroll_q;
  logic [8*N_DIGITS-1:0] seg_q, seg_d;

  logic                 wr_fire;
  logic                 mode_chg;
  logic [PW-1:0]        period;
  logic [PW-1:0]        idx;
  logic [7:0]           gl;

  always_comb begin
    wr_ready = !reset && !clear && (len_q < LW'(BUF_DEPTH));
    wr_fire  = wr_valid && wr_ready;
    mode_chg = (scroll_en != scroll_q);
    period   = PW'(len_q) + PW'(N_DIGITS);
  end

  always_comb begin
    len_d  = len_q;
    pos_d  = pos_q;
    tick_d = tick_q;
    if (clear) begin
      len_d  = '0;
      pos_d  = '0;
      tick_d = '0;
    end else begin
      if (wr_fire) len_d = len_q + LW'(1);
      if (mode_chg) begin
        pos_d  = '0;
        tick_d = '0;
      end else if (scroll_q && len_q != '0) begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          pos_d  = (pos_q == period - PW'(1)) ? '0 : pos_q + PW'(1);
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end else begin
        // Static mode or empty buffer: the scroll position parks at 0.
        pos_d  = '0;
        tick_d = '0;
      end
    end
  end

  // Static mode reads buf[k]; scroll mode reads virtual[(pos+k) mod P], where
  // indices at or beyond len fall into the blank tail. pos < P and k < N_DIGITS
  // <= P, so one conditional subtraction is a full modulo.
  always_comb begin
    seg_d = '1;
    idx   = '0;
    gl    = 8'hFF;
    for (int k = 0; k < N_DIGITS; k++) begin
      idx = scroll_q ? (pos_q + PW'(k)) : PW'(k);
      if (scroll_q && idx >= period) idx = idx - period;
      if (idx < PW'(len_q)) gl = glyph_of(buf_q[idx[AW-1:0]]);
      else                  gl = 8'hFF;
      seg_d[8*(N_DIGITS-1-k) +: 8] = gl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q    <= '0;
      pos_q    <= '0;
      tick_q   <= '0;
      scroll_q <= 1'b0;
      seg_q    <= '1;
    end else begin
      len_q    <= len_d;
      pos_q    <= pos_d;
      tick_q   <= tick_d;
      scroll_q <= scroll_en;
      seg_q    <= seg_d;
    end
  end

  // Character storage needs no reset; only entries below len are ever shown.
  always_ff @(posedge clk) begin
    if (wr_fire) buf_q[len_q[AW-1:0]] <= wr_data;
  end

  assign len     = len_q;
  assign seg_out = seg_q;

endmodule

// File: tb/tb_seg7_text_scroller.sv
module tb_seg7_text_scroller;
  localparam int N = 4;
  localparam int D = 8;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [6:0]  wr_data;
  logic        wr_ready;
  logic        clear;
  logic        scroll_en;
  logic [3:0]  len;
  logic [31:0] seg_out;

  always #5 clk = ~clk;

  seg7_text_scroller #(.N_DIGITS(N), .BUF_DEPTH(D), .TICK_DIV(T)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .clear(clear), .scroll_en(scroll_en),
    .len(len), .seg_out(seg_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  string       tag_q [$];
  logic [31:0] val_q [$];

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic pop_chk();
    string       t;
    logic [31:0] v;
    if (val_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_empty: observed no entry expected one");
    end else begin
      t = tag_q.pop_front();
      v = val_q.pop_front();
      chk(t, seg_out, v);
    end
  endtask

  task automatic wr(input logic [6:0] c);
    wr_valid = 1'b1;
    wr_data  = c;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [6:0] s9 [9];

  initial begin
    s9 = '{7'h41, 7'h42, 7'h48, 7'h49, 7'h30, 7'h2D, 7'h41, 7'h42, 7'h48};
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; clear = 1'b0; scroll_en = 1'b0;

    // Reset
    step(3);
    chk("reset_seg", seg_out, 32'hFFFF_FFFF);
    chk("reset_len", 32'(len), 32'd0);
    chk("reset_ready", 32'(wr_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 32'(wr_ready), 32'd1);

    // Static "HI"
    wr(7'h48);
    wr_data = 7'h49;
    push_exp("static_hi", 32'h89CF_FFFF);
    step();
    chk("static_h_only", seg_out, 32'h89FF_FFFF);
    wr_valid = 1'b0;
    step();
    pop_chk();
    chk("static_len2", 32'(len), 32'd2);

    // Fill to capacity; the 9th character is refused
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_len", 32'(len), 32'd0);
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1;
      wr_data  = s9[i];
      #1;
      chk($sformatf("fill_ready_%0d", i), 32'(wr_ready), (i < 8) ? 32'd1 : 32'd0);
      step();
    end
    wr_valid = 1'b0;
    chk("full_len", 32'(len), 32'd8);
    chk("full_ready", 32'(wr_ready), 32'd0);
    push_exp("full_static", 32'h8883_89CF);
    step();
    pop_chk();

    // Scroll "AB": P = 6, one step every 4 cycles
    clear = 1'b1;
    step();
    clear = 1'b0;
    wr(7'h41);
    wr(7'h42);
    wr_valid  = 1'b0;
    scroll_en = 1'b1;
    push_exp("scroll_s0", 32'h8883_FFFF);
    push_exp("scroll_s1", 32'h83FF_FFFF);
    push_exp("scroll_s2", 32'hFFFF_FFFF);
    push_exp("scroll_s3", 32'hFFFF_FF88);
    push_exp("scroll_s4", 32'hFFFF_8883);
    push_exp("scroll_s5", 32'hFF88_83FF);
    push_exp("scroll_s6_wrap", 32'h8883_FFFF);
    step(2);
    pop_chk();
    step(3);
    chk("scroll_hold_s0", seg_out, 32'h8883_FFFF);
    step();
    pop_chk();
    for (int s = 2; s <= 6; s++) begin
      step(4);
      pop_chk();
    end

    // Clear beats a same-cycle write while scrolling
    clear    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 7'h48;
    #1;
    chk("ready_during_clear", 32'(wr_ready), 32'd0);
    step();
    clear    = 1'b0;
    wr_valid = 1'b0;
    chk("clear_scroll_len", 32'(len), 32'd0);
    push_exp("clear_blank", 32'hFFFF_FFFF);
    step();
    pop_chk();
    chk("clear_write_dropped", 32'(len), 32'd0);

    // Control codes blank, '-' visible; then mode toggles restart the scroll
    scroll_en = 1'b0;
    wr(7'h05);
    wr(7'h7F);
    wr(7'h2D);
    wr_valid = 1'b0;
    push_exp("ctrl_static", 32'hFFFF_BFFF);
    step();
    pop_chk();
    chk("ctrl_len", 32'(len), 32'd3);
    scroll_en = 1'b1;
    push_exp("ctrl_scroll_s1", 32'hFFBF_FFFF);
    step(6);
    pop_chk();
    step();
    scroll_en = 1'b0;
    step();
    scroll_en = 1'b1;
    push_exp("toggle_pos0", 32'hFFFF_BFFF);
    push_exp("toggle_hold", 32'hFFFF_BFFF);
    push_exp("toggle_step1", 32'hFFBF_FFFF);
    step(2);
    pop_chk();
    step(3);
    pop_chk();
    step();
    pop_chk();

    chk("sb_drained", 32'(val_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
